// File: rtl/batcharger_ctrl.sv
// -----------------------------------------------------------------------------
// batcharger_ctrl
//   Li-ion charge controller: trickle (TC), constant current (CC), constant
//   voltage (CV), DONE with recharge, and a temperature fault state (TFLT).
//   Every non-trivial transition is debounced by a single counter that tracks
//   the highest-priority exit condition of the current state.
//
// Ports
//   clk    : system clock, all state changes on rising edge
//   rstz   : asynchronous active-low reset
//   en     : block enable; dropping it returns to OFF on the next edge
//   sel    : capacity select (latched when OFF is left)
//   vbat   : sensed battery voltage code
//   ibat   : sensed battery current code
//   vtbat  : battery temperature code
//   icode  : current setpoint to the power stage (registered)
//   vcode  : voltage setpoint to the power stage (registered)
//   state  : current FSM state, OFF=0 TC=1 CC=2 CV=3 DONE=4 TFLT=5
//   done   : high only in DONE
//   fault  : high in TFLT, or from a CV timeout until the next OFF
//
// Handshake: none; inputs are sampled every cycle, outputs are registered and
// change only on the clock edge on which the state is entered.
// -----------------------------------------------------------------------------
module batcharger_ctrl #(
    parameter int ADCW   = 8,
    parameter int DEB    = 4,
    parameter int ISTEP  = 8,
    parameter int VPRE   = 153,
    parameter int VFLOAT = 214,
    parameter int VRECH  = 204,
    parameter int TLOW   = 62,
    parameter int THIGH  = 131,
    parameter int THYS   = 5,
    parameter int TMRW   = 16,
    parameter int TCVMAX = 1000
) (
    input  logic            clk,
    input  logic            rstz,
    input  logic            en,
    input  logic [3:0]      sel,
    input  logic [ADCW-1:0] vbat,
    input  logic [ADCW-1:0] ibat,
    input  logic [ADCW-1:0] vtbat,
    output logic [ADCW-1:0] icode,
    output logic [ADCW-1:0] vcode,
    output logic [2:0]      state,
    output logic            done,
    output logic            fault
);

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_TC   = 3'd1,
        S_CC   = 3'd2,
        S_CV   = 3'd3,
        S_DONE = 3'd4,
        S_TFLT = 3'd5
    } state_t;

    // Which exit condition the debounce counter is currently accumulating.
    typedef enum logic [1:0] {
        W_NONE = 2'd0,
        W_TEMP = 2'd1,
        W_NORM = 2'd2
    } win_t;

    localparam int PW   = ADCW + 4;
    localparam int CNTW = (DEB > 1) ? $clog2(DEB) : 1;

    localparam logic [PW-1:0]   ISTEP_C  = PW'(ISTEP);
    localparam logic [ADCW-1:0] VPRE_C   = ADCW'(VPRE);
    localparam logic [ADCW-1:0] VFLOAT_C = ADCW'(VFLOAT);
    localparam logic [ADCW-1:0] VRECH_C  = ADCW'(VRECH);
    localparam logic [ADCW-1:0] TLOW_C   = ADCW'(TLOW);
    localparam logic [ADCW-1:0] THIGH_C  = ADCW'(THIGH);
    localparam logic [ADCW-1:0] TLOWN_C  = ADCW'(TLOW + THYS);
    localparam logic [ADCW-1:0] THIGHN_C = ADCW'(THIGH - THYS);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEB - 1);
    localparam logic [TMRW-1:0] TMR_LAST = TMRW'(TCVMAX - 1);

    state_t          state_q, state_d;
    win_t            win_q, win_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [TMRW-1:0] tmr_q, tmr_d;
    logic [3:0]      sel_q, sel_d;
    logic            to_flag_q, to_flag_d;
    logic [ADCW-1:0] icode_q, icode_d;
    logic [ADCW-1:0] vcode_q, vcode_d;
    logic            done_q, done_d;
    logic            fault_q, fault_d;

    logic [3:0]      sel_eff;
    logic [PW-1:0]   prod;
    logic [ADCW-1:0] ichg, itrk, iend;
    logic            temp_ok, temp_ok_n;
    logic            timeout;
    win_t            win;
    state_t          norm_tgt;
    logic [CNTW-1:0] cnt_cur;

    // The capacity latch is loaded on the OFF exit edge, so the setpoint for
    // that first state must come straight from the sel input.
    always_comb begin
        sel_eff = (state_q == S_OFF) ? sel : sel_q;
        prod    = (PW'(sel_eff) + PW'(1)) * ISTEP_C;
        ichg    = (prod[PW-1:ADCW] != '0) ? {ADCW{1'b1}} : prod[ADCW-1:0];
        itrk    = ichg >> 3;
        iend    = ichg >> 4;
    end

    always_comb begin
        temp_ok   = (vtbat >= TLOW_C)  && (vtbat <= THIGH_C);
        temp_ok_n = (vtbat >= TLOWN_C) && (vtbat <= THIGHN_C);
        timeout   = (tmr_q >= TMR_LAST);
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        to_flag_d = to_flag_q;
        win       = W_NONE;
        norm_tgt  = state_q;
        cnt_d     = '0;
        cnt_cur   = '0;

        case (state_q)
            S_OFF: begin
                if (en) begin
                    state_d = (vbat < VPRE_C) ? S_TC : S_CC;
                    sel_d   = sel;
                end
            end
            S_TC: begin
                norm_tgt = S_CC;
                if (!temp_ok)              win = W_TEMP;
                else if (vbat >= VPRE_C)   win = W_NORM;
            end
            S_CC: begin
                norm_tgt = S_CV;
                if (!temp_ok)              win = W_TEMP;
                else if (vbat >= VFLOAT_C) win = W_NORM;
            end
            S_CV: begin
                norm_tgt = S_DONE;
                if (!temp_ok)              win = W_TEMP;
                else if (timeout) begin
                    // Safety timeout is not debounced: it ends CV at once.
                    state_d   = S_DONE;
                    to_flag_d = 1'b1;
                end
                else if (ibat <= iend)     win = W_NORM;
            end
            S_DONE: begin
                norm_tgt = S_CC;
                if (!temp_ok)              win = W_TEMP;
                else if (vbat < VRECH_C)   win = W_NORM;
            end
            S_TFLT: begin
                norm_tgt = (vbat < VPRE_C) ? S_TC : S_CC;
                if (temp_ok_n)             win = W_NORM;
            end
            default: state_d = S_OFF;
        endcase

        // Shared debounce: a change of winning condition restarts the count.
        cnt_cur = (win == win_q) ? cnt_q : '0;
        if (win != W_NONE) begin
            if (cnt_cur == CNT_LAST) begin
                state_d = (win == W_TEMP) ? S_TFLT : norm_tgt;
            end else begin
                cnt_d = cnt_cur + 1'b1;
            end
        end
        win_d = win;

        if (!en) begin
            state_d = S_OFF;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
            win_d = W_NONE;
        end

        if (state_d == S_OFF) begin
            to_flag_d = 1'b0;
        end

        // CV timer: zero on entry and outside CV, saturating inside CV.
        if (state_d == S_CV && state_q == S_CV) begin
            tmr_d = (tmr_q == {TMRW{1'b1}}) ? tmr_q : tmr_q + 1'b1;
        end else begin
            tmr_d = '0;
        end
    end

    // Outputs registered together with the state they belong to.
    always_comb begin
        icode_d = '0;
        vcode_d = '0;
        case (state_d)
            S_TC: icode_d = itrk;
            S_CC, S_CV: begin
                icode_d = ichg;
                vcode_d = VFLOAT_C;
            end
            default: begin
                icode_d = '0;
                vcode_d = '0;
            end
        endcase
        done_d  = (state_d == S_DONE);
        fault_d = (state_d == S_TFLT) || to_flag_d;
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q   <= S_OFF;
            win_q     <= W_NONE;
            cnt_q     <= '0;
            tmr_q     <= '0;
            sel_q     <= '0;
            to_flag_q <= 1'b0;
            icode_q   <= '0;
            vcode_q   <= '0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            sel_q     <= sel_d;
            to_flag_q <= to_flag_d;
            icode_q   <= icode_d;
            vcode_q   <= vcode_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
        end
    end

    assign state = state_q;
    assign icode = icode_q;
    assign vcode = vcode_q;
    assign done  = done_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_batcharger_ctrl.sv
// -----------------------------------------------------------------------------
// tb_batcharger_ctrl
//   Bench for batcharger_ctrl. dut0 uses default parameters; dut1 uses
//   ISTEP=32 to exercise current-code saturation. Expected output tuples are
//   queued when stimulus is applied and popped when the outputs are sampled.
// -----------------------------------------------------------------------------
module tb_batcharger_ctrl;

    localparam int EW = 21; // {state[3], icode[8], vcode[8], done, fault}

    logic       clk;
    logic       rstz;
    logic       en;
    logic [3:0] sel;
    logic [7:0] vbat, ibat, vtbat;

    logic [7:0] icode0, vcode0, icode1, vcode1;
    logic [2:0] state0, state1;
    logic       done0, fault0, done1, fault1;

    batcharger_ctrl dut0 (
        .clk(clk), .rstz(rstz), .en(en), .sel(sel),
        .vbat(vbat), .ibat(ibat), .vtbat(vtbat),
        .icode(icode0), .vcode(vcode0), .state(state0),
        .done(done0), .fault(fault0)
    );

    batcharger_ctrl #(.ISTEP(32)) dut1 (
        .clk(clk), .rstz(rstz), .en(en), .sel(sel),
        .vbat(vbat), .ibat(ibat), .vtbat(vtbat),
        .icode(icode1), .vcode(vcode1), .state(state1),
        .done(done1), .fault(fault1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        logic       en;
        logic [3:0] sel;
        logic [7:0] vbat;
        logic [7:0] ibat;
        logic [7:0] vtbat;
        int         ncyc;
        logic [2:0] st;
        logic [7:0] ic;
        logic [7:0] vc;
        logic       dn;
        logic       ft;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [EW-1:0] pk(input logic [2:0] s, input logic [7:0] i,
                                         input logic [7:0] v, input logic d, input logic f);
        return {s, i, v, d, f};
    endfunction

    function automatic void add(input string nm, input logic e, input logic [3:0] s,
                                input logic [7:0] vb, input logic [7:0] ib, input logic [7:0] vt,
                                input int n, input logic [2:0] st, input logic [7:0] ic,
                                input logic [7:0] vc, input logic dn, input logic ft);
        vec_t r;
        r.name = nm; r.en = e; r.sel = s; r.vbat = vb; r.ibat = ib; r.vtbat = vt;
        r.ncyc = n; r.st = st; r.ic = ic; r.vc = vc; r.dn = dn; r.ft = ft;
        vecs.push_back(r);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic e, input logic [3:0] s, input logic [7:0] vb,
                         input logic [7:0] ib, input logic [7:0] vt);
        en = e; sel = s; vbat = vb; ibat = ib; vtbat = vt;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [2:0] st, input logic [7:0] ic,
                              input logic [7:0] vc, input logic dn, input logic ft);
        exp_q.push_back(pk(st, ic, vc, dn, ft));
    endtask

    task automatic check(input string nm, input bit which);
        logic [EW-1:0] act;
        logic [EW-1:0] exp;
        act = which ? pk(state1, icode1, vcode1, done1, fault1)
                    : pk(state0, icode0, vcode0, done0, fault0);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: no expected entry queued", nm);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_err++;
                $display("FAIL %s (dut%0d): got st=%0d ic=%0d vc=%0d dn=%0b ft=%0b, want st=%0d ic=%0d vc=%0d dn=%0b ft=%0b",
                         nm, which, act[20:18], act[17:10], act[9:2], act[1], act[0],
                         exp[20:18], exp[17:10], exp[9:2], exp[1], exp[0]);
            end
        end
    endtask

    // ---------------- test ----------------
    initial begin
        // OFF=0 TC=1 CC=2 CV=3 DONE=4 TFLT=5; sel=8 -> ichg=72, trickle 9, iend 4
        add("off_idle",      0, 8, 100, 100, 100, 2, 0,  0,   0, 0, 0);
        add("off_to_tc",     1, 8, 100, 100, 100, 1, 1,  9,   0, 0, 0);
        add("tc_deb_3",      1, 8, 160, 100, 100, 3, 1,  9,   0, 0, 0);
        add("tc_to_cc",      1, 8, 160, 100, 100, 1, 2, 72, 214, 0, 0);
        add("cc_deb_3",      1, 8, 214, 100, 100, 3, 2, 72, 214, 0, 0);
        add("cc_to_cv",      1, 8, 214, 100, 100, 1, 3, 72, 214, 0, 0);
        add("cv_deb_3",      1, 8, 214,   4, 100, 3, 3, 72, 214, 0, 0);
        add("cv_to_done",    1, 8, 214,   4, 100, 1, 4,  0,   0, 1, 0);
        add("done_deb_3",    1, 8, 200,   4, 100, 3, 4,  0,   0, 1, 0);
        add("done_to_cc",    1, 8, 200,   4, 100, 1, 2, 72, 214, 0, 0);
        add("cc_hot_3",      1, 8, 200,   4, 140, 3, 2, 72, 214, 0, 0);
        add("cc_to_tflt",    1, 8, 200,   4, 140, 1, 5,  0,   0, 0, 1);
        add("tflt_narrow",   1, 8, 200,   4, 128, 6, 5,  0,   0, 0, 1);
        add("tflt_deb_3",    1, 8, 200,   4, 100, 3, 5,  0,   0, 0, 1);
        add("tflt_to_cc",    1, 8, 200,   4, 100, 1, 2, 72, 214, 0, 0);
        add("cc_en_off",     0, 8, 200,   4, 100, 1, 0,  0,   0, 0, 0);
        add("off_to_tc2",    1, 8, 100, 100, 100, 1, 1,  9,   0, 0, 0);
        add("tc_glitch",     1, 8, 160, 100, 100, 2, 1,  9,   0, 0, 0);
        add("tc_glitch_end", 1, 8, 100, 100, 100, 4, 1,  9,   0, 0, 0);
        add("tc_cold_3",     1, 8, 100, 100,  61, 3, 1,  9,   0, 0, 0);
        add("tc_to_tflt",    1, 8, 100, 100,  61, 1, 5,  0,   0, 0, 1);
        add("tflt_cold_hys", 1, 8, 100, 100,  66, 6, 5,  0,   0, 0, 1);
        add("tflt_deb_3b",   1, 8, 100, 100,  67, 3, 5,  0,   0, 0, 1);
        add("tflt_to_tc",    1, 8, 100, 100,  67, 1, 1,  9,   0, 0, 0);
        add("tc_prio_3",     1, 8, 160, 100, 132, 3, 1,  9,   0, 0, 0);
        add("tc_prio_tflt",  1, 8, 160, 100, 132, 1, 5,  0,   0, 0, 1);
        add("tflt_en_off",   0, 8, 160, 100, 100, 1, 0,  0,   0, 0, 0);
        add("off_to_cc_vpre",1, 8, 153, 100, 100, 1, 2, 72, 214, 0, 0);
        add("cc_en_off2",    0, 8, 153, 100, 100, 1, 0,  0,   0, 0, 0);

        // reset state
        rstz = 1'b1;
        drive(0, 4'd8, 8'd100, 8'd100, 8'd100);
        #1 rstz = 1'b0;
        #2;
        expect_out(0, 0, 0, 0, 0); check("reset_dut0", 0);
        expect_out(0, 0, 0, 0, 0); check("reset_dut1", 1);
        @(posedge clk);
        #1 rstz = 1'b1;

        // table-driven vectors
        foreach (vecs[k]) begin
            drive(vecs[k].en, vecs[k].sel, vecs[k].vbat, vecs[k].ibat, vecs[k].vtbat);
            expect_out(vecs[k].st, vecs[k].ic, vecs[k].vc, vecs[k].dn, vecs[k].ft);
            step(vecs[k].ncyc);
            check(vecs[k].name, 0);
        end

        // CV safety timeout: DONE with fault exactly 1000 cycles after CV entry
        drive(1, 4'd8, 8'd214, 8'd30, 8'd100);
        expect_out(2, 72, 214, 0, 0); step(1); check("to_cc", 0);
        expect_out(3, 72, 214, 0, 0); step(4); check("to_cv_entry", 0);
        expect_out(3, 72, 214, 0, 0); step(999); check("to_cv_999", 0);
        expect_out(4, 0, 0, 1, 1);    step(1); check("to_done_fault", 0);
        drive(1, 4'd8, 8'd200, 8'd30, 8'd100);
        expect_out(2, 72, 214, 0, 1); step(4); check("to_recharge_fault", 0);
        drive(1, 4'd8, 8'd214, 8'd30, 8'd100);
        expect_out(3, 72, 214, 0, 1); step(4); check("to_cv_again", 0);
        drive(0, 4'd8, 8'd214, 8'd30, 8'd100);
        expect_out(0, 0, 0, 0, 0);    step(1); check("cv_en_off", 0);

        // saturation: sel=15 -> 16*8=128 on dut0, 16*32=512 -> 255 on dut1
        drive(1, 4'd15, 8'd100, 8'd100, 8'd100);
        step(1);
        expect_out(1, 16, 0, 0, 0);   check("sat_tc_dut0", 0);
        expect_out(1, 31, 0, 0, 0);   check("sat_tc_dut1", 1);
        drive(1, 4'd15, 8'd160, 8'd100, 8'd100);
        step(4);
        expect_out(2, 128, 214, 0, 0); check("sat_cc_dut0", 0);
        expect_out(2, 255, 214, 0, 0); check("sat_cc_dut1", 1);

        // asynchronous reset mid-CC, then a clean restart with new sel
        #2 rstz = 1'b0;
        #1;
        expect_out(0, 0, 0, 0, 0); check("async_rst_dut0", 0);
        expect_out(0, 0, 0, 0, 0); check("async_rst_dut1", 1);
        @(posedge clk);
        #1 rstz = 1'b1;
        drive(1, 4'd8, 8'd160, 8'd100, 8'd100);
        expect_out(0, 0, 0, 0, 0);    step(0); check("post_rst_off", 0);
        expect_out(2, 72, 214, 0, 0); step(1); check("post_rst_cc", 0);
        expect_out(2, 72, 214, 0, 0); step(4); check("post_rst_cc_hold", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/batcharger_ctrl.md
BATCHARGER_CTRL -- requirements
Module: batcharger_ctrl

Interface
REQ-001 Parameter ADCW, default 8: width of every sensed-value and drive code.
REQ-002 Parameter DEB, default 4: consecutive cycles a transition condition holds before it is taken.
REQ-003 Parameter ISTEP, default 8: charge-current code per capacity step.
REQ-004 Parameters VPRE=153, VFLOAT=214, VRECH=204 (ADCW codes, 5 V full scale): precharge exit, float and recharge thresholds.
REQ-005 Parameters TLOW=62, THIGH=131, THYS=5 (ADCW codes; 0 °C, 45 °C, hysteresis): temperature window.
REQ-006 Parameters TMRW=16, TCVMAX=1000: CV safety timer width and limit in cycles.
REQ-007 clk  input  1  single system clock; all state updates on its rising edge.
REQ-008 rstz  input  1  reset; asynchronous and active-low.
REQ-009 en  input  1  block enable.
REQ-010 sel  input  4  capacity selection; weights 400/200/100/50 mAh plus 50 mAh offset.
REQ-011 vbat  input  ADCW  sensed battery voltage code.
REQ-012 ibat  input  ADCW  sensed battery current code.
REQ-013 vtbat  input  ADCW  battery temperature code.
REQ-014 icode  output  ADCW  current setpoint to power stage.
REQ-015 vcode  output  ADCW  voltage setpoint to power stage.
REQ-016 state  output  3  OFF=0, TC=1, CC=2, CV=3, DONE=4, TFLT=5.
REQ-017 done  output  1  high only in DONE.
REQ-018 fault  output  1  high in TFLT, or after a CV timeout, until the next OFF.

Function
REQ-019 ichg = (sel_q+1)*ISTEP, computed ADCW+4 bits wide and saturated to 2^ADCW-1; sel_q is sel registered on every OFF exit and held until the block returns to OFF.
REQ-020 Trickle current is ichg>>3; end-of-charge current iend is ichg>>4.
REQ-021 icode is 0 in OFF/DONE/TFLT, ichg>>3 in TC, and ichg in CC/CV; vcode is VFLOAT in CC/CV and 0 otherwise; both are registered with the state.
REQ-022 Temperature is in window when TLOW<=vtbat<=THIGH. On re-entry from TFLT the window narrows to TLOW+THYS<=vtbat<=THIGH-THYS.
REQ-023 Debounce: one counter counts consecutive cycles that the current state's exit condition is true; it clears when the condition drops or the state changes; the transition fires on the cycle the count reaches DEB-1, i.e. DEB cycles after the condition rises.
REQ-024 OFF -> TC if en and vbat<VPRE; OFF -> CC if en and vbat>=VPRE. Evaluated the cycle after en rises; no debounce.
REQ-025 TC -> CC when vbat>=VPRE (debounced); CC -> CV when vbat>=VFLOAT (debounced).
REQ-026 CV -> DONE when ibat<=iend (debounced). CV -> DONE with fault=1 when the CV timer reaches TCVMAX.
REQ-027 The CV timer clears on CV entry, increments each CV cycle and saturates; it is not running outside CV.
REQ-028 DONE -> CC when vbat<VRECH (debounced); done deasserts on that transition.
REQ-029 From TC/CC/CV/DONE: temperature out of window (debounced) -> TFLT. TFLT -> TC/CC per REQ-024 once the narrowed window holds (debounced).
REQ-030 Priority, highest first: en=0 -> OFF next cycle, no debounce; then temperature fault; then the normal exit condition.
REQ-031 Simultaneous exit conditions in one state follow the REQ-030 priority; the debounce counter tracks only the winning condition.

Reset
REQ-032 On rstz=0, asynchronously: state=OFF, icode=0, vcode=0, done=0, fault=0, counters=0, sel_q=0.
REQ-033 Reset asserted mid-charge behaves as REQ-032. After release, the block restarts from OFF with no retained history.

Verification
REQ-034 en=1, sel=4'b1000, vbat=100, vtbat=100 -> TC with icode=9; vbat set to 160 -> CC with icode=72, vcode=214, 4 cycles after vbat changes.
REQ-035 In CC, vbat=214 -> CV; ibat=4 for 4 cycles -> DONE, done=1, icode=0; vbat=200 for 4 cycles -> CC, icode=72.
REQ-036 In CC, vtbat=140 for 4 cycles -> TFLT, fault=1, icode=0; vtbat=128 -> stays TFLT; vtbat=100 for 4 cycles -> CC.
REQ-037 In CV, ibat held at 30 -> DONE with fault=1 exactly 1000 cycles after CV entry.
REQ-038 en=0 in CV -> OFF next cycle, icode=0; a 2-cycle vbat>=VPRE glitch in TC -> no transition.
REQ-039 sel=4'b1111 with ISTEP=32 -> icode saturates at 255; rstz pulsed low mid-CC -> all outputs 0 immediately.
